mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Responder end of the cache-line memory interface driven by the eviction write buffer (data side)
//  and by the instruction cache. Accepts line reads from icache and line reads/writes from the
//  data-side write buffer, serialises them onto one physical-memory (cacheline adaptor) port,
//  routes the memory response back to the owner, and keeps per-port grant counters for perf analysis.
// PARAMETERS
//  ADDR_W   32   address width, all ports
//  LINE_W   256  cache-line data width, all ports
//  CNT_W    32   width of each grant counter (saturating)
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous reset, active-low (rst==0 resets)
//  i_read         in   1       icache line read request, held until i_resp
//  i_address      in   ADDR_W  icache line address
//  i_rdata        out  LINE_W  line to icache, valid only with i_resp
//  i_resp         out  1       one-cycle completion to icache
//  d_read         in   1       data-side (write buffer) line read request, held until d_resp
//  d_write        in   1       data-side line write request, held until d_resp
//  d_address      in   ADDR_W  data-side line address
//  d_wdata        in   LINE_W  data-side write line
//  d_rdata        out  LINE_W  line to data side, valid only with d_resp
//  d_resp         out  1       one-cycle completion to data side
//  mem_read       out  1       memory line read
//  mem_write      out  1       memory line write
//  mem_address    out  ADDR_W  memory address (registered at grant)
//  mem_wdata      out  LINE_W  memory write line (registered at grant)
//  mem_rdata      in   LINE_W  memory read line
//  mem_resp       in   1       memory completion, one cycle
//  i_grant_count  out  CNT_W   icache grants since reset
//  d_grant_count  out  CNT_W   data-side grants since reset
// BEHAVIOUR
//  - States: IDLE, I_READ, D_READ, D_WRITE. Grants made only in IDLE.
//  - IDLE, request sampled in cycle N: grant at edge ending N; mem_read/mem_write asserted from N+1
//    and held until mem_resp. Address/wdata latched at grant; later input changes ignored.
//  - Data side: d_write beats d_read if both high (protocol violation); D_WRITE drives mem_write.
//  - Both ports pending in IDLE: grant the port NOT granted last (last_grant reg, reset = data side,
//    so icache wins the first tie). Single pending port is granted immediately.
//  - Serving state with mem_resp=1: owner resp=1 same cycle, owner rdata=mem_rdata (combinational);
//    next state IDLE. The non-owner's resp is 0 and rdata is 0. Both rdata are 0 whenever their resp is 0.
//  - Mandatory IDLE cycle after each completion: a request still high in it is a new request.
//    Back-to-back same-port transactions each take >= mem latency + 1 cycles.
//  - mem_resp in IDLE ignored (no resp generated, no state change).
//  - Counters: +1 on each grant of that port; saturate at 2^CNT_W-1, no wrap.
//  - Reset values: state IDLE, mem_read=0, mem_write=0, i_resp=0, d_resp=0, rdata outputs 0,
//    mem_address=0, mem_wdata=0, counters 0, last_grant=data side.
//  - rst low mid-transaction: next cycle IDLE with all outputs at reset values; in-flight memory
//    transaction is abandoned, no resp issued; mem_resp arriving later is ignored (IDLE rule).
//  - Counters and last_grant change only on grants; a held request is never granted twice.
// TESTING
//  1 i_read=1, addr 0x0000_1000, mem_resp after 3 cycles with rdata=0xA5..A5 -> mem_read high
//    cycles 1-3, mem_address 0x1000, i_resp=1 with i_rdata=0xA5..A5 in mem_resp cycle, i_grant_count=1.
//  2 d_write=1, addr 0x0000_2040, wdata=0x1234..; change d_wdata after grant -> mem_write with
//    latched 0x1234.., d_resp on mem_resp, d_rdata=0, d_grant_count=1.
//  3 i_read and d_read both held for 4 transactions after reset -> grant order I,D,I,D;
//    each pair of completions separated by exactly one IDLE cycle.
//  4 d_read and d_write both high -> D_WRITE chosen, mem_write=1, mem_read=0 throughout.
//  5 rst=0 while mem_read high, then mem_resp=1 two cycles after release -> outputs at reset
//    values, no i_resp/d_resp, state IDLE, counters 0.
//  6 Preload CNT_W=4, 17 icache grants -> i_grant_count holds at 15; mem_resp pulse in IDLE -> no resp.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port cache-line arbiter: icache reads and data-side reads/writes share one memory port.
// Round-robin on ties, registered memory request, combinational response routing.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [CNT_W-1:0]  i_grant_count,
  output logic [CNT_W-1:0]  d_grant_count
);

  // state   | meaning
  // IDLE    | no transaction in flight, grants are made here
  // I_READ  | icache line read on memory port
  // D_READ  | data-side line read on memory port
  // D_WRITE | data-side line write on memory port
  typedef enum logic [1:0] {IDLE, I_READ, D_READ, D_WRITE} state_t;

  state_t state;
  logic   last_d;
  logic   d_req;
  logic   grant_i;
  logic   grant_d;

  assign d_req = d_read | d_write;
  // On a tie the port that was not granted last wins.
  assign grant_i = i_read && (!d_req || last_d);
  assign grant_d = d_req && !grant_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      last_d        <= 1'b1;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_wdata     <= '0;
      i_grant_count <= '0;
      d_grant_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state       <= I_READ;
            mem_read    <= 1'b1;
            mem_address <= i_address;
            last_d      <= 1'b0;
            if (i_grant_count != '1) i_grant_count <= i_grant_count + 1'b1;
          end else if (grant_d) begin
            mem_address <= d_address;
            last_d      <= 1'b1;
            if (d_grant_count != '1) d_grant_count <= d_grant_count + 1'b1;
            // A write wins over a simultaneous read on the data side.
            if (d_write) begin
              state     <= D_WRITE;
              mem_write <= 1'b1;
              mem_wdata <= d_wdata;
            end else begin
              state     <= D_READ;
              mem_read  <= 1'b1;
            end
          end
        end
        default: begin
          if (mem_resp) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    i_resp  = (state == I_READ) && mem_resp;
    d_resp  = ((state == D_READ) || (state == D_WRITE)) && mem_resp;
    i_rdata = i_resp ? mem_rdata : '0;
    d_rdata = d_resp ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single transfers, tie round-robin, write priority,
// reset abort and counter saturation (counters built 4 bits wide).
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;
  logic [CW-1:0] i_grant_count;
  logic [CW-1:0] d_grant_count;

  int total = 0;
  int bad   = 0;

  logic [LW-1:0] pat_a5;
  logic [LW-1:0] pat_w1;
  logic [LW-1:0] pat_w2;
  logic [LW-1:0] pat_rd;
  logic          cap_ir, cap_dr;
  logic [LW-1:0] cap_ird, cap_drd;
  bit            got_op;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Wait n cycles, then pulse mem_resp with rd for one cycle and capture the routed response.
  // The requester(s) drop their request in the response cycle when drop is set.
  task automatic mem_reply(input int n, input logic [LW-1:0] rd, input bit drop);
    repeat (n) @(negedge clk);
    mem_resp  = 1'b1;
    mem_rdata = rd;
    #1;
    cap_ir  = i_resp;
    cap_dr  = d_resp;
    cap_ird = i_rdata;
    cap_drd = d_rdata;
    if (drop) begin
      i_read  = 1'b0;
      d_read  = 1'b0;
      d_write = 1'b0;
    end
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic wait_op();
    got_op = 1'b0;
    for (int k = 0; k < 20 && !got_op; k++) begin
      @(negedge clk);
      if (mem_read || mem_write) got_op = 1'b1;
    end
    if (!got_op) chk("op_timeout", 0, 1);
  endtask

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_w1 = {16{16'h1234}};
    pat_w2 = {16{16'hBEEF}};
    pat_rd = {8{32'hCAFE_0001}};

    do_reset();
    @(negedge clk);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_icnt", i_grant_count, 0);
    chk("rst_dcnt", d_grant_count, 0);
    chk("rst_resps", {i_resp, d_resp}, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);

    // 1: icache read, memory latency 3
    i_read = 1'b1; i_address = 32'h0000_1000;
    #1 chk("t1_no_early_read", mem_read, 0);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk("t1_mem_read", mem_read, 1);
      chk("t1_mem_address", mem_address, 32'h1000);
      chk("t1_no_resp", i_resp, 0);
    end
    chk("t1_icnt", i_grant_count, 1);
    mem_reply(1, pat_a5, 1'b1);
    chk("t1_i_resp", cap_ir, 1);
    chk("t1_i_rdata", cap_ird, pat_a5);
    chk("t1_d_resp", cap_dr, 0);
    chk("t1_d_rdata", cap_drd, 0);
    chk("t1_idle_read", mem_read, 0);
    chk("t1_idle_rdata", i_rdata, 0);

    // 2: data-side write, inputs changed after grant
    d_write = 1'b1; d_address = 32'h0000_2040; d_wdata = pat_w1;
    @(negedge clk);
    chk("t2_mem_write", mem_write, 1);
    chk("t2_mem_read", mem_read, 0);
    d_wdata = pat_w2; d_address = 32'h0000_3000;
    @(negedge clk);
    chk("t2_wdata_latched", mem_wdata, pat_w1);
    chk("t2_addr_latched", mem_address, 32'h2040);
    chk("t2_dcnt", d_grant_count, 1);
    mem_reply(1, '0, 1'b1);
    chk("t2_d_resp", cap_dr, 1);
    chk("t2_d_rdata", cap_drd, 0);
    chk("t2_i_resp", cap_ir, 0);
    chk("t2_dcnt_hold", d_grant_count, 1);

    // 3: both held after reset -> I,D,I,D with one IDLE cycle between
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_0100;
    d_read = 1'b1; d_address = 32'h0000_0200;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("t3_mem_read", mem_read, 1);
      chk("t3_owner_addr", mem_address, (t % 2 == 0) ? 32'h100 : 32'h200);
      mem_reply(1, pat_rd ^ LW'(t), t == 3);
      chk("t3_resp_route", {cap_ir, cap_dr}, (t % 2 == 0) ? 2'b10 : 2'b01);
      chk("t3_rdata", (t % 2 == 0) ? cap_ird : cap_drd, pat_rd ^ LW'(t));
      chk("t3_idle_gap", mem_read, 0);
    end
    chk("t3_icnt", i_grant_count, 2);
    chk("t3_dcnt", d_grant_count, 2);

    // 4: d_read and d_write together -> write
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_4000; d_wdata = pat_w2;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t4_mem_write", mem_write, 1);
      chk("t4_mem_read", mem_read, 0);
    end
    chk("t4_wdata", mem_wdata, pat_w2);
    mem_reply(0, '0, 1'b1);
    chk("t4_d_resp", cap_dr, 1);
    chk("t4_mem_idle", {mem_read, mem_write}, 0);

    // 5: reset mid-transaction, late mem_resp ignored
    i_read = 1'b1; i_address = 32'h0000_5000;
    @(negedge clk);
    chk("t5_mem_read", mem_read, 1);
    rst = 1'b0; i_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("t5_read_cleared", mem_read, 0);
    chk("t5_addr_cleared", mem_address, 0);
    chk("t5_wdata_cleared", mem_wdata, 0);
    chk("t5_cnts", {i_grant_count, d_grant_count}, 0);
    @(negedge clk);
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = pat_a5;
    #1;
    chk("t5_no_resp", {i_resp, d_resp}, 0);
    chk("t5_no_rdata", i_rdata | d_rdata, 0);
    @(negedge clk);
    mem_resp = 1'b0; mem_rdata = '0;
    chk("t5_still_idle", {mem_read, mem_write}, 0);

    // 6: 17 icache grants saturate a 4-bit counter
    do_reset();
    for (int g = 0; g < 17; g++) begin
      i_read = 1'b1; i_address = AW'(g) << 5;
      wait_op();
      mem_reply(0, pat_a5, 1'b1);
      if (g == 14) chk("t6_cnt_at_15", i_grant_count, 15);
    end
    chk("t6_icnt_sat", i_grant_count, 15);
    chk("t6_dcnt", d_grant_count, 0);
    mem_resp = 1'b1; mem_rdata = pat_a5;
    #1;
    chk("t6_idle_resp", {i_resp, d_resp}, 0);
    @(negedge clk);
    mem_resp = 1'b0; mem_rdata = '0;
    chk("t6_idle_state", {mem_read, mem_write}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
